// File: rtl/uart_baud_pkg.sv
// Shared types and constants for the UART baud configuration sequencer:
// FSM states, reset defaults and the 40 MHz / 16x preset table.
package uart_baud_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REJECT,
        HOLD,
        APPLY,
        WAIT_BAUD,
        DONE,
        TOUT
    } cfg_state_t;

    localparam logic [2:0]  CUSTOM_SEL    = 3'd7;
    localparam logic [15:0] RESET_PERIOD  = 16'd20;
    localparam logic [7:0]  RESET_COMP    = 8'hB5;
    localparam logic [2:0]  RESET_SEL_DEF = 3'd4;

    typedef struct packed {
        logic [15:0] period;
        logic [7:0]  comp;
    } baud_preset_t;

    // Index 7 is reserved; it returns the reset setting but is never applied.
    function automatic baud_preset_t preset_lookup(input logic [2:0] sel);
        baud_preset_t entry;
        case (sel)
            3'd0:    entry = '{period: 16'd259, comp: 8'h79};
            3'd1:    entry = '{period: 16'd129, comp: 8'h3D};
            3'd2:    entry = '{period: 16'd64,  comp: 8'h2E};
            3'd3:    entry = '{period: 16'd42,  comp: 8'h6A};
            3'd4:    entry = '{period: 16'd20,  comp: 8'hB5};
            3'd5:    entry = '{period: 16'd9,   comp: 8'hE2};
            3'd6:    entry = '{period: 16'd4,   comp: 8'h79};
            default: entry = '{period: RESET_PERIOD, comp: RESET_COMP};
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/baud_preset_rom.sv
// Combinational preset index -> {AcqPeriod, BitCompensation} lookup.
module baud_preset_rom
    import uart_baud_pkg::*;
(
    input  logic [2:0]  sel,
    output logic [15:0] period,
    output logic [7:0]  comp,
    output logic        valid
);

    baud_preset_t entry;

    always_comb begin
        entry  = preset_lookup(sel);
        period = entry.period;
        comp   = entry.comp;
        valid  = (sel != CUSTOM_SEL);
    end

endmodule

// File: rtl/baud_cfg_ctrl.sv
// Baud-change sequencer: validates a request, holds the UART core idle,
// drives the new generator setting and confirms it via two BaudSig pulses.
module baud_cfg_ctrl
    import uart_baud_pkg::*;
#(
    parameter int          TIMEOUT_W  = 24,
    parameter logic [15:0] MIN_PERIOD = 16'd3,
    parameter logic [2:0]  RESET_SEL  = RESET_SEL_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_req_i,
    input  logic        cfg_custom_i,
    input  logic [2:0]  cfg_sel_i,
    input  logic [15:0] cfg_period_i,
    input  logic [7:0]  cfg_comp_i,
    output logic        cfg_busy_o,
    output logic        cfg_ack_o,
    output logic        cfg_err_o,
    input  logic        core_busy_i,
    output logic        core_hold_o,
    input  logic        BaudSig_i,
    output logic [15:0] AcqPeriod_o,
    output logic [7:0]  BitCompensation_o,
    output logic [2:0]  cur_sel_o
);

    localparam baud_preset_t RESET_ENTRY = preset_lookup(RESET_SEL);
    localparam logic [TIMEOUT_W-1:0] TOUT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    cfg_state_t state, state_next;

    logic [15:0] rom_period;
    logic [7:0]  rom_comp;
    logic        rom_valid;
    logic        req_valid;

    logic [15:0] new_period, bak_period;
    logic [7:0]  new_comp, bak_comp;
    logic [2:0]  new_sel, bak_sel;
    logic        pulse_seen;
    logic [TIMEOUT_W-1:0] tout_cnt;

    baud_preset_rom u_rom (
        .sel    (cfg_sel_i),
        .period (rom_period),
        .comp   (rom_comp),
        .valid  (rom_valid)
    );

    always_comb begin
        req_valid  = cfg_custom_i ? ((cfg_period_i >= MIN_PERIOD) && (cfg_comp_i != 8'h00))
                                  : rom_valid;
        state_next = state;
        case (state)
            IDLE:      if (cfg_req_i) state_next = req_valid ? HOLD : REJECT;
            REJECT:    state_next = IDLE;
            HOLD:      if (!core_busy_i) state_next = APPLY;
            APPLY:     state_next = WAIT_BAUD;
            // The first pulse may still carry the old setting; only the second proves the switch.
            WAIT_BAUD: begin
                if (BaudSig_i && pulse_seen)  state_next = DONE;
                else if (tout_cnt == TOUT_LAST) state_next = TOUT;
            end
            DONE:      state_next = IDLE;
            TOUT:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_busy_o  <= 1'b0;
            cfg_ack_o   <= 1'b0;
            cfg_err_o   <= 1'b0;
            core_hold_o <= 1'b0;
        end else begin
            cfg_busy_o  <= (state_next != IDLE);
            cfg_ack_o   <= state_next inside {REJECT, DONE, TOUT};
            cfg_err_o   <= state_next inside {REJECT, TOUT};
            core_hold_o <= state_next inside {HOLD, APPLY, WAIT_BAUD, DONE, TOUT};
        end
    end

    // The request is resolved to concrete generator values at capture time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            AcqPeriod_o       <= RESET_ENTRY.period;
            BitCompensation_o <= RESET_ENTRY.comp;
            cur_sel_o         <= RESET_SEL;
            bak_period        <= RESET_ENTRY.period;
            bak_comp          <= RESET_ENTRY.comp;
            bak_sel           <= RESET_SEL;
            new_period        <= '0;
            new_comp          <= '0;
            new_sel           <= '0;
            pulse_seen        <= 1'b0;
            tout_cnt          <= '0;
        end else begin
            if (state == IDLE && cfg_req_i) begin
                new_period <= cfg_custom_i ? cfg_period_i : rom_period;
                new_comp   <= cfg_custom_i ? cfg_comp_i   : rom_comp;
                new_sel    <= cfg_custom_i ? CUSTOM_SEL   : cfg_sel_i;
            end
            case (state)
                APPLY: begin
                    bak_period        <= AcqPeriod_o;
                    bak_comp          <= BitCompensation_o;
                    bak_sel           <= cur_sel_o;
                    AcqPeriod_o       <= new_period;
                    BitCompensation_o <= new_comp;
                    cur_sel_o         <= new_sel;
                    pulse_seen        <= 1'b0;
                    tout_cnt          <= '0;
                end
                WAIT_BAUD: begin
                    tout_cnt <= tout_cnt + TIMEOUT_W'(1);
                    if (BaudSig_i) pulse_seen <= 1'b1;
                end
                TOUT: begin
                    AcqPeriod_o       <= bak_period;
                    BitCompensation_o <= bak_comp;
                    cur_sel_o         <= bak_sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/baud_cfg_ctrl.md
Name: baud_cfg_ctrl

Overview:
Configuration sequencer for the UART baudrate generator.
- Accepts baud-change requests: either a preset index or custom period/compensation values.
- Stalls new TX/RX frames and waits for the core to go idle.
- Drives the generator's AcqPeriod/BitCompensation inputs, then confirms the generator has latched them by counting BaudSig pulses.
- Returns a single-cycle ack, with an error flag on rejection or timeout.
- Sits in UartCore between the register interface and the baudrate module.

Parameters:
- TIMEOUT_W, 24: width of the WAIT_BAUD timeout counter; timeout occurs at 2^TIMEOUT_W-1 cycles.
- MIN_PERIOD, 16'd3: smallest custom AcqPeriod accepted.
- RESET_SEL, 3'd4: preset index applied at reset (115200).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- cfg_req_i  in  1  single-cycle request pulse
- cfg_custom_i  in  1  1 = use cfg_period_i/cfg_comp_i; 0 = use the preset cfg_sel_i
- cfg_sel_i  in  3  preset index
- cfg_period_i  in  16  custom acquisition period
- cfg_comp_i  in  8  custom compensation: [7:4] up count, [3:0] down count
- cfg_busy_o  out  1  high whenever the FSM is not in IDLE
- cfg_ack_o  out  1  one-cycle completion pulse
- cfg_err_o  out  1  valid with cfg_ack_o; 1 = rejected or timed out
- core_busy_i  in  1  TX or RX frame in progress
- core_hold_o  out  1  forbids TX/RX from starting a new frame
- BaudSig_i  in  1  baud pulse from the baudrate module
- AcqPeriod_o  out  16  to baudrate module AcqPeriod_i
- BitCompensation_o  out  8  to baudrate module BitCompensation_i
- cur_sel_o  out  3  active preset index; 3'd7 when a custom setting is active

Behaviour:
- Reset values:
  - AcqPeriod_o = 16'd20, BitCompensation_o = 8'hB5, cur_sel_o = 3'd4.
  - cfg_busy_o, cfg_ack_o, cfg_err_o, core_hold_o all 0.
  - FSM in IDLE; all counters 0.
  - A reset mid-operation aborts the sequence and restores these values.
- FSM states:
  - IDLE: a cfg_req_i pulse captures custom/sel/period/comp into holding registers.
    - Invalid request (preset index 7, custom period < MIN_PERIOD, or custom comp == 8'h00) → REJECT.
    - Valid request → HOLD.
  - REJECT: cfg_ack_o = 1 and cfg_err_o = 1 for one cycle → IDLE. Outputs unchanged.
  - HOLD: core_hold_o = 1; stays until core_busy_i is sampled 0 → APPLY. There is no timeout in this state.
  - APPLY: one cycle. At the exit edge, the previous outputs are saved into backup registers and the new AcqPeriod_o, BitCompensation_o and cur_sel_o are registered. Clear the pulse and timeout counters → WAIT_BAUD.
  - WAIT_BAUD: counts BaudSig_i pulses.
    - Exit to DONE on the 2nd pulse. The first pulse may reflect a latch of the old values; the second guarantees the new values are in use.
    - The timeout counter increments every cycle; at all-ones → TOUT.
  - DONE: cfg_ack_o = 1, cfg_err_o = 0 for one cycle; core_hold_o drops on the same edge → IDLE.
  - TOUT: restore the outputs from backup; cfg_ack_o = 1 and cfg_err_o = 1 for one cycle; release hold → IDLE.
- Handshake rules:
  - cfg_req_i is ignored whenever the FSM is not in IDLE; there is no queuing.
  - A request arriving in the same cycle as the ack is ignored.
  - Latency from request to ack for REJECT: 2 cycles (request edge + ack cycle).
- Outputs are registered and stable in every state except at the APPLY exit edge and the TOUT restore edge.
- BaudSig_i is treated as a 1-cycle pulse. A pulse in the same cycle as the APPLY exit edge is not counted.

Decomposition:
- Package uart_baud_pkg:
  - FSM state enum (IDLE, REJECT, HOLD, APPLY, WAIT_BAUD, DONE, TOUT).
  - CUSTOM_SEL = 3'd7.
  - Reset constants.
  - Preset table for 40 MHz, 16x acquisition, entries {period, comp}:
    - 0: 9600 = {259, 8'h79}
    - 1: 19200 = {129, 8'h3D}
    - 2: 38400 = {64, 8'h2E}
    - 3: 57600 = {42, 8'h6A}
    - 4: 115200 = {20, 8'hB5}
    - 5: 230400 = {9, 8'hE2}
    - 6: 460800 = {4, 8'h79}
    - 7: reserved
- One natural sub-module, baud_preset_rom: a combinational index → {period, comp} lookup with a valid output.

Test Plan:
- Reset → AcqPeriod_o = 20, BitCompensation_o = 8'hB5, cur_sel_o = 4, all flags 0.
- Preset sel = 0 request, core_busy_i = 0, BaudSig_i pulses every 50 cycles → APPLY outputs 259/8'h79; ack with err = 0 after the 2nd pulse; core_hold_o high from the cycle after the request to the ack; cur_sel_o = 0.
- Request with core_busy_i high for 100 cycles → outputs unchanged and core_hold_o = 1 throughout; APPLY occurs the cycle after busy drops.
- sel = 7, then custom period = 2, then custom comp = 0 → each ack with err = 1 two cycles after the request; outputs unchanged; core_hold_o never asserted.
- Custom period 1000 / comp 8'hA6 with BaudSig_i held 0 → TOUT after 2^24-1 cycles in WAIT_BAUD: ack with err = 1; outputs restored to the prior values.
- Assert rst low during WAIT_BAUD → all outputs return to reset values immediately; a second request during HOLD is ignored.
